// File: rtl/fft_regime_sequencer.sv
// ---------------------------------------------------------------------------
// fft_regime_sequencer
//
// Sequences test runs of the 8-point FFT datapath. It selects a signal_gen
// regime, waits out the signal_gen register stage plus the FFT pipeline
// latency, presents a tagged valid/ready result handshake, dwells, and then
// either steps to the next regime (sweep mode) or finishes with a done pulse.
//
// Parameters
//   N        log2 of FFT size; width of regime and res_tag
//   FFT_LAT  FFT pipeline latency in cycles (>= 1)
//   DWELL    cycles a result is held after the handshake (>= 1)
//   CW       internal counter width; must hold max(FFT_LAT, DWELL)
//
// Ports
//   clk            in   single clock, posedge
//   rst_n          in   synchronous active-low reset
//   start          in   begin a run (sampled only in IDLE)
//   abort          in   cancel the run in progress
//   mode           in   0 = single regime, 1 = sweep 0..2^N-1 (latched at start)
//   manual_regime  in   regime used when mode = 0 (latched at start)
//   regime         out  regime select to signal_gen
//   busy           out  high in every state except IDLE
//   res_valid      out  FFT output corresponds to res_tag; held until res_ready
//   res_ready      in   consumer accepts the result
//   res_tag        out  regime that produced the current result
//   done           out  one-cycle pulse when a run completes normally
// ---------------------------------------------------------------------------
module fft_regime_sequencer #(
    parameter int N       = 3,
    parameter int FFT_LAT = 4,
    parameter int DWELL   = 16,
    parameter int CW      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         mode,
    input  logic [N-1:0] manual_regime,
    output logic [N-1:0] regime,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_tag,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_PRESENT,
        S_DWELL
    } state_t;

    localparam logic [CW-1:0] LAT_LAST    = CW'(FFT_LAT - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);
    localparam logic [N-1:0]  REGIME_LAST = {N{1'b1}};

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sweep;   // mode latched at start

    // All outputs are state bits updated here, so no input reaches an output
    // combinationally.
    // NOTE: every register in this block uses non-blocking assignment so all
    // updates of one edge see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sweep     <= 1'b0;
            regime    <= '0;
            res_tag   <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;   // pulse by default

            if (state != S_IDLE && abort) begin
                // Abort beats everything, including a same-cycle handshake;
                // regime and res_tag are left where they are.
                state     <= S_IDLE;
                busy      <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            sweep  <= mode;
                            regime <= mode ? '0 : manual_regime;
                            busy   <= 1'b1;
                            state  <= S_SETTLE;
                        end
                    end

                    // One cycle for the signal_gen register stage.
                    S_SETTLE: begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end

                    S_WAIT: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAT_LAST) begin
                            res_valid <= 1'b1;
                            res_tag   <= regime;
                            state     <= S_PRESENT;
                        end
                    end

                    S_PRESENT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            cnt       <= '0;
                            state     <= S_DWELL;
                        end
                    end

                    S_DWELL: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == DWELL_LAST) begin
                            if (sweep && regime != REGIME_LAST) begin
                                regime <= regime + 1'b1;
                                state  <= S_SETTLE;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end

                    default: begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_regime_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_regime_sequencer
//
// Self-checking bench for fft_regime_sequencer: a cycle table for a single
// manual run, hand-written sequences for backpressure, abort, ignored start
// and mid-run reset, and randomized runs checked against a transaction-level
// model (expected tag queue plus latency arithmetic).
// ---------------------------------------------------------------------------
module tb_fft_regime_sequencer;

    localparam int N       = 3;
    localparam int FFT_LAT = 4;
    localparam int DWELL   = 16;
    localparam int CW      = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         mode;
    logic [N-1:0] manual_regime;
    logic [N-1:0] regime;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_tag;
    logic         done;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    fft_regime_sequencer #(
        .N(N), .FFT_LAT(FFT_LAT), .DWELL(DWELL), .CW(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .manual_regime(manual_regime),
        .regime       (regime),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_tag      (res_tag),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         abort;
        logic         mode;
        logic [N-1:0] man;
        logic         ready;
        int           n;        // cycles this row is applied and checked
        logic [N-1:0] e_regime;
        logic         e_busy;
        logic         e_valid;
        logic [N-1:0] e_tag;
        logic         e_done;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one edge; outputs are examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_outs(input string name, input logic [N-1:0] e_regime,
                              input logic e_busy, input logic e_valid,
                              input logic [N-1:0] e_tag, input logic e_done);
        check({name, " regime"},    32'(regime),    32'(e_regime));
        check({name, " busy"},      32'(busy),      32'(e_busy));
        check({name, " res_valid"}, 32'(res_valid), 32'(e_valid));
        check({name, " res_tag"},   32'(res_tag),   32'(e_tag));
        check({name, " done"},      32'(done),      32'(e_done));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        manual_regime = '0; res_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!res_valid && k < 64) begin
            step();
            k++;
        end
        check({name, " valid reached"}, 32'(res_valid), 32'd1);
    endtask

    task automatic wait_regime(input string name, input logic [N-1:0] r);
        int k = 0;
        while (regime != r && k < 1000) begin
            step();
            k++;
        end
        check({name, " regime reached"}, 32'(regime), 32'(r));
    endtask

    // Randomized-run model state
    logic [N-1:0] exp_q[$];
    logic [N-1:0] hs_tag;
    logic [N-1:0] exp_tag;
    int           ref_cyc, last_hs;
    bit           first, got_done, prev_valid, hs, mode_r;
    logic [N-1:0] man_r;

    initial begin
        // Single manual run, regime 5, consumer always ready.
        // start accepted at edge T; valid after T+1+FFT_LAT; handshake at the
        // next edge; done DWELL edges after the handshake.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1,         3'd5, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, FFT_LAT,   3'd5, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1,         3'd5, 1'b1, 1'b1, 3'd5, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1,         3'd5, 1'b1, 1'b0, 3'd5, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, DWELL - 1, 3'd5, 1'b1, 1'b0, 3'd5, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1,         3'd5, 1'b0, 1'b0, 3'd5, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3,         3'd5, 1'b0, 1'b0, 3'd5, 1'b0};

        do_reset();
        check_outs("reset", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // ---- table-driven single run ----
        for (int i = 0; i < NV; i++) begin
            start         = vecs[i].start;
            abort         = vecs[i].abort;
            mode          = vecs[i].mode;
            manual_regime = vecs[i].man;
            res_ready     = vecs[i].ready;
            for (int k = 0; k < vecs[i].n; k++) begin
                step();
                check_outs($sformatf("vec%0d.%0d", i, k), vecs[i].e_regime,
                           vecs[i].e_busy, vecs[i].e_valid, vecs[i].e_tag, vecs[i].e_done);
            end
        end

        // ---- backpressure: ready low for 10 cycles in PRESENT ----
        do_reset();
        start = 1'b1; mode = 1'b0; manual_regime = 3'd2; res_ready = 1'b0;
        step();
        start = 1'b0;
        wait_valid("bp");
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("bp hold%0d valid", k), 32'(res_valid), 32'd1);
            check($sformatf("bp hold%0d tag", k),   32'(res_tag),   32'd2);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp accept valid", 32'(res_valid), 32'd0);
        check("bp accept busy",  32'(busy),      32'd1);
        for (int k = 0; k < DWELL - 1; k++) begin
            step();
            check($sformatf("bp dwell%0d done", k), 32'(done), 32'd0);
        end
        step();
        check("bp done", 32'(done), 32'd1);

        // ---- abort during WAIT in a sweep at regime 3 ----
        do_reset();
        start = 1'b1; mode = 1'b1; res_ready = 1'b1;
        step();
        start = 1'b0;
        wait_regime("abort", 3'd3);   // now in SETTLE
        step();                       // now in WAIT
        abort = 1'b1;
        step();
        abort = 1'b0;
        res_ready = 1'b0;
        check_outs("abort", 3'd3, 1'b0, 1'b0, 3'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_outs($sformatf("abort idle%0d", k), 3'd3, 1'b0, 1'b0, 3'd2, 1'b0);
        end

        // ---- start while busy is ignored; start+abort in IDLE stays IDLE ----
        do_reset();
        start = 1'b1; mode = 1'b0; manual_regime = 3'd1; res_ready = 1'b0;
        step();
        step();
        start = 1'b1; mode = 1'b1; manual_regime = 3'd6;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("busy start%0d regime", k), 32'(regime), 32'd1);
        end
        start = 1'b0;
        wait_valid("busy start");
        check("busy start tag", 32'(res_tag), 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        for (int k = 0; k < DWELL - 1; k++) step();
        step();
        check("busy start done",   32'(done),   32'd1);
        check("busy start regime", 32'(regime), 32'd1);
        for (int k = 0; k < FFT_LAT + 3; k++) begin
            step();
            check($sformatf("busy start no rerun%0d", k), 32'(busy), 32'd0);
        end
        start = 1'b1; abort = 1'b1; mode = 1'b0; manual_regime = 3'd4;
        step();
        start = 1'b0; abort = 1'b0;
        check("start+abort busy",   32'(busy),   32'd0);
        check("start+abort regime", 32'(regime), 32'd1);
        step();
        check("start+abort still idle", 32'(busy), 32'd0);

        // ---- reset mid-sweep at regime 4 ----
        do_reset();
        start = 1'b1; mode = 1'b1; res_ready = 1'b1;
        step();
        start = 1'b0;
        wait_regime("rst", 3'd4);
        step();
        step();
        rst_n = 1'b0;
        step();
        check_outs("mid reset", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        step();
        check_outs("after reset", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // ---- randomized runs vs transaction model ----
        do_reset();
        for (int r = 0; r < 6; r++) begin
            mode_r = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            man_r  = N'($urandom_range(0, 7));
            exp_q.delete();
            if (mode_r) begin
                for (int t = 0; t < 8; t++) exp_q.push_back(N'(t));
            end else begin
                exp_q.push_back(man_r);
            end

            start = 1'b1; mode = mode_r; manual_regime = man_r; res_ready = 1'b0;
            step();
            start = 1'b0;
            mode = 1'($urandom_range(0, 1));          // must not matter once latched
            manual_regime = N'($urandom_range(0, 7));
            ref_cyc = cyc; last_hs = cyc; first = 1'b1;
            got_done = 1'b0; prev_valid = 1'b0;

            for (int k = 0; k < 2000 && !got_done; k++) begin
                res_ready = ($urandom_range(0, 3) != 0);
                hs = res_valid && res_ready;
                hs_tag = res_tag;
                if (hs) check($sformatf("rnd%0d regime=tag", r), 32'(regime), 32'(res_tag));
                step();
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("rnd%0d extra handshake", r), 32'd1, 32'd0);
                    end else begin
                        exp_tag = exp_q.pop_front();
                        check($sformatf("rnd%0d tag", r), 32'(hs_tag), 32'(exp_tag));
                    end
                    ref_cyc = cyc; last_hs = cyc; first = 1'b0;
                end
                if (res_valid && !prev_valid)
                    check($sformatf("rnd%0d latency", r), 32'(cyc - ref_cyc),
                          first ? 32'(FFT_LAT + 1) : 32'(DWELL + FFT_LAT + 1));
                prev_valid = res_valid;
                if (done) begin
                    got_done = 1'b1;
                    check($sformatf("rnd%0d done time", r), 32'(cyc - last_hs), 32'(DWELL));
                    check($sformatf("rnd%0d tags left", r), 32'(exp_q.size()), 32'd0);
                    check($sformatf("rnd%0d busy", r), 32'(busy), 32'd0);
                    check($sformatf("rnd%0d final regime", r), 32'(regime),
                          mode_r ? 32'd7 : 32'(man_r));
                end
            end
            if (!got_done) check($sformatf("rnd%0d done seen", r), 32'd0, 32'd1);
            res_ready = 1'b0;
            step();
            check($sformatf("rnd%0d single done", r), 32'(done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
